exercicio_05: RTL and testbench
===============================

Name: exercicio_05

Overview:
- Registered 8-bit subtractor: diferenca = hex - quaternario, with borrow and zero flags.
- quaternario carries a 4-digit base-4 number, 2 bits per digit, MSB digit in bits [7:6]. Example: digits 1,2,3,2 encode as 8'b01_10_11_10 = 8'h6E.
- Sits in the arithmetic exercise datapath and feeds status/display logic downstream.

Parameters:
- WIDTH, 8, operand and result width in bits; must be even, because each base-4 digit is 2 bits.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- hex  input  WIDTH  minuend, plain binary; the bench writes it in hex notation.
- quaternario  input  WIDTH  subtrahend, base-4 digits packed 2 bits each.
- out_valid  output  1  result registers updated from a valid input on the previous edge.
- diferenca  output  WIDTH  registered difference.
- borrow  output  1  set when hex < quaternario (unsigned underflow).
- zero  output  1  set when the registered diferenca equals 0.

Behaviour:
- Reset: synchronous, active-high. On a rising edge with rst=1: out_valid=0, diferenca=0, borrow=0, zero=1. rst has priority over in_valid.
- Latency: exactly 1 cycle.
  - With in_valid=1 at edge N, the results appear after edge N and out_valid=1 for that one cycle.
  - out_valid returns to 0 on the next edge unless in_valid is high again.
- No backpressure. A new operand pair is accepted on every valid cycle; back-to-back inputs produce back-to-back outputs.
- When in_valid=0: diferenca, borrow and zero hold their last values; out_valid=0.
- Arithmetic:
  - Compute a WIDTH+1-bit unsigned difference {1'b0,hex} - {1'b0,quaternario}.
  - diferenca = low WIDTH bits, i.e. wrap-around modulo 2^WIDTH.
  - borrow = bit WIDTH of that result.
  - zero is derived from the value actually registered into diferenca.
- Boundary cases:
  - Equal operands -> diferenca=0, borrow=0, zero=1.
  - hex=0, quaternario=max -> diferenca=1, borrow=1.
  - hex=max, quaternario=0 -> diferenca=max, borrow=0.
- All 2^WIDTH encodings of quaternario are legal, since every 2-bit digit is a valid base-4 digit. No input validation is required.
- Reset mid-operation: an input accepted on the same edge as rst=1 is discarded.
- No X propagation from outputs after the first reset.

Optional Feature:
- Macro: EXERCICIO_05_SAT_EN.
- Defined: on underflow (borrow=1), diferenca saturates to 0, and therefore zero=1; borrow still reports 1.
- Not defined: wrap-around result as specified in Behaviour.
- Latency, handshake and reset values are identical in both builds.

Decomposition:
- Package exercicio_05_pkg:
  - WIDTH default (8)
  - QDIGIT_W = 2
  - QDIGITS = WIDTH/QDIGIT_W
  - reset constant for diferenca (all zeros)
- One combinational sub-module, exercicio_05_sub. It takes a, b and produces diff and borrow using the WIDTH+1-bit subtraction, plus saturation under the macro.
- The top module holds only the registers and the valid pipeline.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs and in_valid=1 -> out_valid=0, diferenca=8'h00, borrow=0, zero=1.
- Nominal: hex=8'hC4, quaternario=8'h6E (base-4 1232), in_valid=1 for one cycle -> next cycle diferenca=8'h56 (8'b01010110), borrow=0, zero=0, out_valid=1; the following cycle out_valid=0 and outputs hold.
- Underflow: hex=8'h6E, quaternario=8'hC4 -> diferenca=8'hAA, borrow=1. With EXERCICIO_05_SAT_EN: diferenca=8'h00, borrow=1, zero=1.
- Equal/extremes, back-to-back over three cycles: (8'h55,8'h55) -> 8'h00, zero=1; (8'h00,8'hFF) -> 8'h01, borrow=1; (8'hFF,8'h00) -> 8'hFF, borrow=0. Results must appear on three consecutive cycles.
- Reset mid-operation: in_valid=1 with (8'h10,8'h01) on the same edge as rst=1 -> outputs at reset values, out_valid=0; the next valid input is processed normally.

Source files
------------

// File: rtl/exercicio_05_pkg.sv
// Shared constants for the exercicio_05 registered subtractor.
// Optional build macro: EXERCICIO_05_SAT_EN (saturate underflow to zero).
package exercicio_05_pkg;

  // Default operand/result width. It must stay even because each base-4 digit is 2 bits.
  localparam int WIDTH_DEF = 8;

  // Bits per base-4 digit, and the digit count at the default width.
  localparam int QDIGIT_W = 2;
  localparam int QDIGITS  = WIDTH_DEF / QDIGIT_W;

  // Value loaded into diferenca by reset.
  localparam logic [WIDTH_DEF-1:0] DIFERENCA_RST = '0;

endpackage

// File: rtl/exercicio_05_sub.sv
// Combinational WIDTH-bit subtractor producing difference and borrow.
// Optional build macro: EXERCICIO_05_SAT_EN clamps the difference to 0 on underflow.
module exercicio_05_sub
  import exercicio_05_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // The extra top bit of the widened subtraction is the unsigned borrow.
  logic [WIDTH:0] full;

  assign full   = {1'b0, a} - {1'b0, b};
  assign borrow = full[WIDTH];

`ifdef EXERCICIO_05_SAT_EN
  // Saturating build: on underflow, report 0 instead of the wrapped value.
  assign diff = full[WIDTH] ? '0 : full[WIDTH-1:0];
`else
  // Default build: wrap modulo 2^WIDTH.
  assign diff = full[WIDTH-1:0];
`endif

endmodule

// File: rtl/exercicio_05.sv
// exercicio_05: registered subtractor diferenca = hex - quaternario.
// quaternario holds base-4 digits packed 2 bits each (MSB digit in the top bits).
// The output registers add one cycle of latency. Results hold while in_valid is low.
// Optional build macro: EXERCICIO_05_SAT_EN (saturate underflow to zero, borrow still set).
module exercicio_05
  import exercicio_05_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] hex,
  input  logic [WIDTH-1:0] quaternario,
  output logic             out_valid,
  output logic [WIDTH-1:0] diferenca,
  output logic             borrow
  ,
  output logic             zero
);

  // Reject an odd width at elaboration, because digits would straddle the packing.
  if ((WIDTH % QDIGIT_W) != 0) begin : g_width_check
    $error("exercicio_05: WIDTH must be a multiple of QDIGIT_W");
  end

  logic [WIDTH-1:0] diff_next;
  logic             borrow_next;

  exercicio_05_sub #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a      (hex),
    .b      (quaternario),
    .diff   (diff_next),
    .borrow (borrow_next)
  );

  // Result and valid registers. Reset wins over a same-edge valid input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      diferenca <= WIDTH'(DIFERENCA_RST);
      borrow    <= 1'b0;
      zero      <= 1'b1;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diferenca <= diff_next;
        borrow    <= borrow_next;
        // Derive zero from the value actually registered, so it tracks saturation too.
        zero      <= (diff_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_exercicio_05.sv
// Self-checking bench for exercicio_05.
// It uses table-driven back-to-back vectors plus hand-written reset, hold and mid-op reset sequences.
// Expected values follow EXERCICIO_05_SAT_EN when the bench is built with it.
module tb_exercicio_05;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] hex;
  logic [W-1:0] quaternario;
  logic         out_valid;
  logic [W-1:0] diferenca;
  logic         borrow;
  logic         zero;

  int n_checks = 0;
  int n_fails  = 0;

  exercicio_05 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .hex         (hex),
    .quaternario (quaternario),
    .out_valid   (out_valid),
    .diferenca   (diferenca),
    .borrow      (borrow),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         z;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ov, input logic [W-1:0] d,
                     input logic bo, input logic z);
    n_checks++;
    if (out_valid !== ov) begin
      n_fails++;
      $display("FAIL %s out_valid got %b want %b", name, out_valid, ov);
    end
    n_checks++;
    if (diferenca !== d) begin
      n_fails++;
      $display("FAIL %s diferenca got %h want %h", name, diferenca, d);
    end
    n_checks++;
    if (borrow !== bo) begin
      n_fails++;
      $display("FAIL %s borrow got %b want %b", name, borrow, bo);
    end
    n_checks++;
    if (zero !== z) begin
      n_fails++;
      $display("FAIL %s zero got %b want %b", name, zero, z);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout out_valid=%b want finish", out_valid);
    $fatal(1, "timeout");
  end

  initial begin
    // These are hand-computed results for the back-to-back table.
    vecs[0] = '{8'hC4, 8'h6E, 8'h56, 1'b0, 1'b0};
`ifdef EXERCICIO_05_SAT_EN
    vecs[1] = '{8'h6E, 8'hC4, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 8'hFF, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h01, 8'h02, 8'h00, 1'b1, 1'b1};
`else
    vecs[1] = '{8'h6E, 8'hC4, 8'hAA, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
`endif
    vecs[2] = '{8'h55, 8'h55, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b0};

    // Reset for two cycles while random operands are valid.
    rst = 1'b1;
    in_valid = 1'b1;
    hex = 8'($urandom);
    quaternario = 8'($urandom);
    tick();
    chk("reset_c1", 1'b0, 8'h00, 1'b0, 1'b1);
    hex = 8'($urandom);
    quaternario = 8'($urandom);
    tick();
    chk("reset_c2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Apply one nominal operand pair, then check that the result holds.
    rst = 1'b0;
    in_valid = 1'b1;
    hex = 8'hC4;
    quaternario = 8'h6E;
    tick();
    chk("nominal", 1'b1, 8'h56, 1'b0, 1'b0);
    in_valid = 1'b0;
    hex = 8'h00;
    quaternario = 8'h01;
    tick();
    chk("nominal_hold", 1'b0, 8'h56, 1'b0, 1'b0);

    // Apply the table back-to-back, with one result expected per cycle.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      hex = vecs[i].a;
      quaternario = vecs[i].b;
      tick();
      chk($sformatf("vec%0d", i), 1'b1, vecs[i].d, vecs[i].bo, vecs[i].z);
    end
    in_valid = 1'b0;
    hex = 8'h33;
    quaternario = 8'h11;
    tick();
    chk("table_hold", 1'b0, vecs[6].d, vecs[6].bo, vecs[6].z);

    // Assert reset on the same edge as a valid input, then process the next input normally.
    rst = 1'b1;
    in_valid = 1'b1;
    hex = 8'h10;
    quaternario = 8'h01;
    tick();
    chk("midop_reset", 1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    chk("after_reset", 1'b1, 8'h0F, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("after_reset_idle", 1'b0, 8'h0F, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
